sr_cmd_encoder: RTL
===================

Name: sr_cmd_encoder

Overview:
- Command-side driver for the sr_flipflop storage cell: accepts a requested bit over a valid/ready handshake and converts it into a legal S or R pulse.
- Reads Q/Qbar feedback to confirm the write, retries on mismatch, and raises a sticky fault when retries are exhausted.
- By construction, S=R=1 is never driven.

Parameters:
- PULSE_CYCLES, 1, cycles S or R is held high per attempt (≥1)
- SETTLE_CYCLES, 1, idle cycles after the pulse before feedback is sampled (≥1)
- MAX_RETRY, 2, extra attempts after the first failed check (≥0)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_data  in  1  target value for Q
- req_ready  out  1  encoder can accept (high iff state IDLE)
- S  out  1  set command to flip-flop (registered)
- R  out  1  reset command to flip-flop (registered)
- q_fb  in  1  Q from flip-flop
- qbar_fb  in  1  Qbar from flip-flop
- done  out  1  one-cycle pulse: write confirmed
- err  out  1  sticky fault flag
- err_clr  in  1  clears fault, returns to IDLE

Behaviour:
- Reset (async, takes effect immediately):
  - S=0, R=0, done=0, err=0; state=IDLE; retry count=0; timer=0.
  - req_ready=1 while in IDLE, including during reset.
- States are IDLE, DRIVE, SETTLE, CHECK, FAULT.
- IDLE:
  - req_valid & req_ready at an edge latches req_data into the target register; next state DRIVE.
  - Retry count is cleared on acceptance.
- DRIVE:
  - Target=1 drives S=1, R=0; target=0 drives R=1, S=0.
  - Held for exactly PULSE_CYCLES cycles, then SETTLE.
- SETTLE: S=R=0 for SETTLE_CYCLES cycles, then CHECK.
- CHECK (single cycle, S=R=0):
  - Pass condition: q_fb==target and qbar_fb==~target. On pass: done=1 next cycle; state IDLE.
  - On failure with retry<MAX_RETRY: retry++, state DRIVE.
  - On failure otherwise: state FAULT.
  - q_fb==qbar_fb (illegal cell state) always counts as a failure.
- FAULT:
  - err=1, req_ready=0, S=R=0.
  - err_clr=1 at an edge gives IDLE and err=0 next cycle. err_clr is ignored in all other states.
- Timing with PULSE_CYCLES=P, SETTLE_CYCLES=T, handshake at edge 0:
  - S/R is high in cycles 1..P.
  - CHECK occurs at cycle P+T+1.
  - done and req_ready are both high at cycle P+T+2.
  - Each retry adds P+T+1 cycles.
- Handshake rules:
  - req_valid while not ready is ignored; no queuing.
  - req_data is sampled only at acceptance.
- Invariant: S&R==0 in every cycle, in every state, and through reset.
- Timer width is $clog2(max(P,T)+1). Retry counter width is $clog2(MAX_RETRY+1), minimum 1.

Optional Feature:
- Macro: SR_CMD_ENCODER_SKIP_EN.
- Defined: in IDLE at acceptance, if q_fb==req_data and qbar_fb==~req_data:
  - No pulse is driven.
  - The state goes directly to IDLE with done=1 in the next cycle, so the request completes in 1 cycle.
- Undefined: every accepted request goes through DRIVE, SETTLE and CHECK regardless of feedback.

Decomposition:
- Package sr_cmd_pkg:
  - typedef enum logic [2:0] sr_enc_state_t {IDLE, DRIVE, SETTLE, CHECK, FAULT}.
  - Default constants DEF_PULSE_CYCLES, DEF_SETTLE_CYCLES, DEF_MAX_RETRY.
- One sub-module, sr_pulse_timer:
  - Loadable down-counter with a zero flag.
  - Reused for both the DRIVE and SETTLE intervals.

Test Plan:
- Basic set: defaults, encoder connected to a live sr_flipflop, reset then request data=1 at cycle 0 -> S=1 only in cycle 1, R=0 throughout, done=1 and req_ready=1 at cycle 4, Q=1.
- Basic clear: request data=0 from Q=1 -> R=1 in cycle 1, done at cycle 4, Q=0, err=0.
- Stuck feedback: q_fb forced 0, qbar_fb forced 1, request data=1, MAX_RETRY=2 -> three S pulses at cycles 1, 4 and 7, then err=1, req_ready=0. Pulse err_clr -> err=0, req_ready=1 next cycle.
- Reset mid-operation: PULSE_CYCLES=3, assert reset during the second DRIVE cycle -> S drops to 0 immediately without waiting for a clock edge; state IDLE, err=0 after release.
- Skip feature: Q already 1, request data=1 -> with SR_CMD_ENCODER_SKIP_EN, no S pulse and done at cycle 1; without it, an S pulse occurs and done arrives at cycle 4.
- Randomized stream plus protocol checks:
  - 200 random requests, back-to-back valid, random P in 1..4 and T in 1..4 -> assertion S&R==0 never fires.
  - Every accepted request yields exactly one done or one err.
  - Forcing q_fb==qbar_fb==1 is treated as a mismatch.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and defaults for the SR flip-flop command encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sr_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    FAULT
  } sr_enc_state_t;

  localparam int DEF_PULSE_CYCLES  = 1;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam int DEF_MAX_RETRY     = 2;

  // Larger of two interval lengths; sizes the shared pulse/settle timer.
  function automatic int sr_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with a zero flag, shared by the DRIVE and SETTLE intervals.
// Latency: a load of N reports zero N cycles later; a load of 0 reports zero immediately.
// Backpressure: none; the counter free-runs down to zero and holds there.
module sr_pulse_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_cmd_encoder.sv
// Turns a requested bit into a legal S or R pulse, verifies Q/Qbar, retries, and faults when retries run out.
// Latency: done arrives PULSE_CYCLES+SETTLE_CYCLES+1 cycles after acceptance; each retry adds the same amount.
// Backpressure: req_ready is high only in IDLE, so there is no queuing. Optional macro SR_CMD_ENCODER_SKIP_EN skips writes that are already satisfied.
module sr_cmd_encoder
  import sr_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_data,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic done,
  output logic err,
  input  logic err_clr
);

  localparam int TW = $clog2(sr_max(PULSE_CYCLES, SETTLE_CYCLES) + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  sr_enc_state_t   state, state_nxt;
  logic            target, target_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic            s_nxt, r_nxt, done_nxt, err_nxt;
  logic            accept, fb_ok, skip;
  logic            timer_load, timer_zero;
  logic [TW-1:0]   timer_val;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Q==Qbar never matches target and ~target together, so an illegal cell state fails here.
  assign fb_ok = (q_fb == target) && (qbar_fb == ~target);

`ifdef SR_CMD_ENCODER_SKIP_EN
  assign skip = (q_fb == req_data) && (qbar_fb == ~req_data);
`else
  assign skip = 1'b0;
`endif

  // Reload the timer on entry into each timed interval; a retry re-enters DRIVE from CHECK.
  assign timer_load = ((state_nxt == DRIVE)  && (state != DRIVE)) ||
                      ((state_nxt == SETTLE) && (state != SETTLE));
  assign timer_val  = (state_nxt == DRIVE) ? PULSE_LOAD : SETTLE_LOAD;

  sr_pulse_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = skip ? IDLE : DRIVE;
      DRIVE:   if (timer_zero) state_nxt = SETTLE;
      SETTLE:  if (timer_zero) state_nxt = CHECK;
      CHECK: begin
        if (fb_ok)                    state_nxt = IDLE;
        else if (retry < RETRY_LIMIT) state_nxt = DRIVE;
        else                          state_nxt = FAULT;
      end
      FAULT:   if (err_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; S and R share one target bit, so they are never both high.
  always_comb begin
    target_nxt = accept ? req_data : target;
    retry_nxt  = retry;
    if (accept) begin
      retry_nxt = '0;
    end else if ((state == CHECK) && (state_nxt == DRIVE)) begin
      retry_nxt = retry + RW'(1);
    end
    s_nxt    = (state_nxt == DRIVE) &&  target_nxt;
    r_nxt    = (state_nxt == DRIVE) && !target_nxt;
    done_nxt = ((state == CHECK) && fb_ok) || (accept && skip);
    err_nxt  = (state_nxt == FAULT);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target <= 1'b0;
      retry  <= '0;
      S      <= 1'b0;
      R      <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      target <= target_nxt;
      retry  <= retry_nxt;
      S      <= s_nxt;
      R      <= r_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

endmodule
